// File: rtl/tdpr_pkg.sv
// Shared definitions for the true dual-port byte-enable RAM:
// read-during-write mode encodings and the controller state type.
package tdpr_pkg;

    // Same-port read-during-write behaviour selected by RDW_MODE
    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;
    localparam int RDW_NO_CHANGE   = 2;

    // Controller states: clear sweep after reset, then normal service
    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } tdpr_state_t;

endpackage

// File: rtl/tdpr_be_lane_mux.sv
// Per-lane write merge for the two RAM ports.
// When both ports hit the same word in one cycle, the two writes are folded
// into a single port-A write (A owns a lane if it enables it, otherwise B's
// data is used) and port B's write is suppressed. Also produces the
// "new word" each port would see in write-first mode.
module tdpr_be_lane_mux #(
    parameter int DATA_SIZE = 32,
    parameter int BYTE_SIZE = 8,
    parameter int NBYTES    = DATA_SIZE / BYTE_SIZE
) (
    input  logic                 i_same_addr,
    input  logic [NBYTES-1:0]    i_we_a,
    input  logic [NBYTES-1:0]    i_we_b,
    input  logic [DATA_SIZE-1:0] i_din_a,
    input  logic [DATA_SIZE-1:0] i_din_b,
    input  logic [DATA_SIZE-1:0] i_old_a,
    input  logic [DATA_SIZE-1:0] i_old_b,
    output logic [NBYTES-1:0]    o_wen_a,
    output logic [NBYTES-1:0]    o_wen_b,
    output logic [DATA_SIZE-1:0] o_wdata_a,
    output logic [DATA_SIZE-1:0] o_wdata_b,
    output logic [DATA_SIZE-1:0] o_new_a,
    output logic [DATA_SIZE-1:0] o_new_b
);

    assign o_wdata_b = i_din_b;

    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
        localparam int LO = gi * BYTE_SIZE;

        // Port A absorbs B's lanes on a same-address collision
        assign o_wen_a[gi] = i_we_a[gi] | (i_same_addr & i_we_b[gi]);
        assign o_wen_b[gi] = i_we_b[gi] & ~i_same_addr;

        // A has priority where both ports enable the lane
        assign o_wdata_a[LO +: BYTE_SIZE] = i_we_a[gi] ? i_din_a[LO +: BYTE_SIZE]
                                                       : i_din_b[LO +: BYTE_SIZE];

        // Word as it will look after this cycle's writes
        assign o_new_a[LO +: BYTE_SIZE] = o_wen_a[gi] ? o_wdata_a[LO +: BYTE_SIZE]
                                                      : i_old_a[LO +: BYTE_SIZE];
        assign o_new_b[LO +: BYTE_SIZE] = i_same_addr ? o_new_a[LO +: BYTE_SIZE]
                                        : (i_we_b[gi] ? i_din_b[LO +: BYTE_SIZE]
                                                      : i_old_b[LO +: BYTE_SIZE]);
    end

endmodule

// File: rtl/tdpr_be_ram.sv
// True dual-port RAM with per-byte write enables, same-address collision
// merge/flag, selectable read-during-write behaviour and a post-reset
// zero-clear sweep (init_busy high while it runs, ports ignored).
// Optional macro TDPR_OUT_REG_EN adds one output register stage per port
// (read data and dval latency 2; coll stays at latency 1).
module tdpr_be_ram
    import tdpr_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 32,
    parameter int BYTE_SIZE = 8,
    parameter int RDW_MODE  = 0,
    localparam int NBYTES   = DATA_SIZE / BYTE_SIZE,
    localparam int RAM_SIZE = 2 ** ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 init_busy,
    input  logic                 en_a,
    input  logic                 en_b,
    input  logic [NBYTES-1:0]    we_a,
    input  logic [NBYTES-1:0]    we_b,
    input  logic [ADDR_SIZE-1:0] addr_a,
    input  logic [ADDR_SIZE-1:0] addr_b,
    input  logic [DATA_SIZE-1:0] din_a,
    input  logic [DATA_SIZE-1:0] din_b,
    output logic [DATA_SIZE-1:0] dout_a,
    output logic [DATA_SIZE-1:0] dout_b,
    output logic                 dval_a,
    output logic                 dval_b,
    output logic                 coll
);

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = '1;

    logic [DATA_SIZE-1:0] r_mem [RAM_SIZE];

    tdpr_state_t          r_state;
    logic [ADDR_SIZE-1:0] r_cnt;
    logic                 w_ready;

    // Port-indexed views: index 0 is port A, index 1 is port B
    logic                 w_acc     [2];
    logic [NBYTES-1:0]    w_we      [2];
    logic [DATA_SIZE-1:0] w_old     [2];
    logic [DATA_SIZE-1:0] w_new     [2];
    logic [NBYTES-1:0]    w_wen     [2];
    logic [DATA_SIZE-1:0] w_wdata   [2];
    logic                 w_rd_upd  [2];
    logic [DATA_SIZE-1:0] w_rd_data [2];
    logic                 w_same_acc;

    logic [DATA_SIZE-1:0] r_dout [2];
    logic                 r_dval [2];
    logic                 r_coll;

    assign w_ready   = (r_state == ST_READY);
    assign init_busy = (r_state == ST_INIT);

    assign w_acc[0] = w_ready & en_a;
    assign w_acc[1] = w_ready & en_b;
    assign w_we[0]  = w_acc[0] ? we_a : '0;
    assign w_we[1]  = w_acc[1] ? we_b : '0;
    assign w_old[0] = r_mem[addr_a];
    assign w_old[1] = r_mem[addr_b];

    assign w_same_acc = w_acc[0] & w_acc[1] & (addr_a == addr_b);

    tdpr_be_lane_mux #(
        .DATA_SIZE (DATA_SIZE),
        .BYTE_SIZE (BYTE_SIZE),
        .NBYTES    (NBYTES)
    ) u_lane_mux (
        .i_same_addr (w_same_acc),
        .i_we_a      (w_we[0]),
        .i_we_b      (w_we[1]),
        .i_din_a     (din_a),
        .i_din_b     (din_b),
        .i_old_a     (w_old[0]),
        .i_old_b     (w_old[1]),
        .o_wen_a     (w_wen[0]),
        .o_wen_b     (w_wen[1]),
        .o_wdata_a   (w_wdata[0]),
        .o_wdata_b   (w_wdata[1]),
        .o_new_a     (w_new[0]),
        .o_new_b     (w_new[1])
    );

    // Controller: clear sweep over every address, then serve the ports
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else if (r_state == ST_INIT) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_ADDR) begin
                r_state <= ST_READY;
            end
        end
    end

    // Memory array: zero sweep in INIT, byte-lane writes in READY (not reset)
    always_ff @(posedge clk) begin
        if (!w_ready) begin
            r_mem[r_cnt] <= '0;
        end else begin
            for (int i = 0; i < NBYTES; i++) begin
                if (w_wen[1][i]) begin
                    r_mem[addr_b][i*BYTE_SIZE +: BYTE_SIZE] <= w_wdata[1][i*BYTE_SIZE +: BYTE_SIZE];
                end
                if (w_wen[0][i]) begin
                    r_mem[addr_a][i*BYTE_SIZE +: BYTE_SIZE] <= w_wdata[0][i*BYTE_SIZE +: BYTE_SIZE];
                end
            end
        end
    end

    // Decide per port whether dout is refreshed this cycle and with what
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd_upd[p]  = 1'b0;
            w_rd_data[p] = w_old[p];
            if (w_acc[p]) begin
                if (w_we[p] == '0) begin
                    w_rd_upd[p] = 1'b1;
                end else if (RDW_MODE == RDW_WRITE_FIRST) begin
                    w_rd_upd[p]  = 1'b1;
                    w_rd_data[p] = w_new[p];
                end else if (RDW_MODE == RDW_READ_FIRST) begin
                    w_rd_upd[p] = 1'b1;
                end
            end
        end
    end

    // First output stage: dout holds unless refreshed, dval strobes refresh
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                r_dout[p] <= '0;
                r_dval[p] <= 1'b0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                r_dval[p] <= w_rd_upd[p];
                if (w_rd_upd[p]) begin
                    r_dout[p] <= w_rd_data[p];
                end
            end
        end
    end

    // Collision flag: same word, both ports active, at least one writing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_coll <= 1'b0;
        end else begin
            r_coll <= w_same_acc & ((|w_we[0]) | (|w_we[1]));
        end
    end

    assign coll = r_coll;

`ifdef TDPR_OUT_REG_EN
    logic [DATA_SIZE-1:0] r_dout_q [2];
    logic                 r_dval_q [2];

    // Extra output stage: delays data and strobe by one cycle together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                r_dout_q[p] <= '0;
                r_dval_q[p] <= 1'b0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                r_dout_q[p] <= r_dout[p];
                r_dval_q[p] <= r_dval[p];
            end
        end
    end

    assign dout_a = r_dout_q[0];
    assign dout_b = r_dout_q[1];
    assign dval_a = r_dval_q[0];
    assign dval_b = r_dval_q[1];
`else
    assign dout_a = r_dout[0];
    assign dout_b = r_dout[1];
    assign dval_a = r_dval[0];
    assign dval_b = r_dval[1];
`endif

endmodule

// File: tb/tb_tdpr_be_ram.sv
// Testbench for tdpr_be_ram: three instances (read-first, write-first,
// no-change) share one stimulus stream; a word-level memory model is
// compared against all outputs every cycle, plus literal spot checks.
// Honours TDPR_OUT_REG_EN for the expected read latency.
module tb_tdpr_be_ram;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NB = 4;
    localparam int RS = 256;
`ifdef TDPR_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en_a = 1'b0, en_b = 1'b0;
    logic [NB-1:0] we_a = '0, we_b = '0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [DW-1:0] din_a = '0, din_b = '0;

    logic [DW-1:0] dout_a [3];
    logic [DW-1:0] dout_b [3];
    logic          dval_a [3];
    logic          dval_b [3];
    logic          coll   [3];
    logic          busy   [3];

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        tdpr_be_ram #(
            .ADDR_SIZE (AW),
            .DATA_SIZE (DW),
            .BYTE_SIZE (8),
            .RDW_MODE  (gi)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .init_busy (busy[gi]),
            .en_a      (en_a),
            .en_b      (en_b),
            .we_a      (we_a),
            .we_b      (we_b),
            .addr_a    (addr_a),
            .addr_b    (addr_b),
            .din_a     (din_a),
            .din_b     (din_b),
            .dout_a    (dout_a[gi]),
            .dout_b    (dout_b[gi]),
            .dval_a    (dval_a[gi]),
            .dval_b    (dval_b[gi]),
            .coll      (coll[gi])
        );
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_mem [RS];
    int            m_busy;
    logic [DW-1:0] e1_d [3][2];
    logic [DW-1:0] e2_d [3][2];
    logic          e1_v [3][2];
    logic          e2_v [3][2];
    logic          e_coll;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int i = 0; i < RS; i++) m_mem[i] = '0;
                m_busy = RS;
                e_coll = 1'b0;
                for (int m = 0; m < 3; m++)
                    for (int p = 0; p < 2; p++) begin
                        e1_d[m][p] = '0; e2_d[m][p] = '0;
                        e1_v[m][p] = 1'b0; e2_v[m][p] = 1'b0;
                    end
            end else begin
                for (int m = 0; m < 3; m++)
                    for (int p = 0; p < 2; p++) begin
                        e2_d[m][p] = e1_d[m][p];
                        e2_v[m][p] = e1_v[m][p];
                    end
                if (m_busy > 0) begin
                    m_busy--;
                    e_coll = 1'b0;
                    for (int m = 0; m < 3; m++)
                        for (int p = 0; p < 2; p++) e1_v[m][p] = 1'b0;
                end else begin
                    logic [DW-1:0] old_w [2];
                    logic [DW-1:0] new_w [2];
                    logic          en_p  [2];
                    logic [NB-1:0] we_p  [2];
                    old_w[0] = m_mem[addr_a];
                    old_w[1] = m_mem[addr_b];
                    en_p[0] = en_a; en_p[1] = en_b;
                    we_p[0] = we_a; we_p[1] = we_b;
                    // B applied first so A wins overlapping lanes
                    for (int i = 0; i < NB; i++) begin
                        if (en_b && we_b[i]) m_mem[addr_b][i*8 +: 8] = din_b[i*8 +: 8];
                        if (en_a && we_a[i]) m_mem[addr_a][i*8 +: 8] = din_a[i*8 +: 8];
                    end
                    new_w[0] = m_mem[addr_a];
                    new_w[1] = m_mem[addr_b];
                    for (int m = 0; m < 3; m++)
                        for (int p = 0; p < 2; p++) begin
                            e1_v[m][p] = 1'b0;
                            if (en_p[p]) begin
                                if (we_p[p] == '0) begin
                                    e1_d[m][p] = old_w[p]; e1_v[m][p] = 1'b1;
                                end else if (m == 0) begin
                                    e1_d[m][p] = old_w[p]; e1_v[m][p] = 1'b1;
                                end else if (m == 1) begin
                                    e1_d[m][p] = new_w[p]; e1_v[m][p] = 1'b1;
                                end
                            end
                        end
                    e_coll = en_a && en_b && (addr_a == addr_b) && (we_a != '0 || we_b != '0);
                end
            end
        end
    end

    function automatic logic [DW-1:0] xd(input int m, input int p);
`ifdef TDPR_OUT_REG_EN
        return e2_d[m][p];
`else
        return e1_d[m][p];
`endif
    endfunction

    function automatic logic xv(input int m, input int p);
`ifdef TDPR_OUT_REG_EN
        return e2_v[m][p];
`else
        return e1_v[m][p];
`endif
    endfunction

    // Cycle-by-cycle compare of every instance against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int m = 0; m < 3; m++) begin
                chk($sformatf("m%0d_dout_a", m), dout_a[m], xd(m, 0));
                chk($sformatf("m%0d_dout_b", m), dout_b[m], xd(m, 1));
                chk($sformatf("m%0d_dval_a", m), {31'd0, dval_a[m]}, {31'd0, xv(m, 0)});
                chk($sformatf("m%0d_dval_b", m), {31'd0, dval_b[m]}, {31'd0, xv(m, 1)});
                chk($sformatf("m%0d_coll", m), {31'd0, coll[m]}, {31'd0, e_coll});
                chk($sformatf("m%0d_busy", m), {31'd0, busy[m]}, {31'd0, (m_busy > 0)});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic op(input logic ea, input logic [NB-1:0] wa, input logic [AW-1:0] aa,
                      input logic [DW-1:0] da, input logic eb, input logic [NB-1:0] wb,
                      input logic [AW-1:0] ab, input logic [DW-1:0] db);
        @(negedge clk);
        en_a = ea; we_a = wa; addr_a = aa; din_a = da;
        en_b = eb; we_b = wb; addr_b = ab; din_b = db;
    endtask

    task automatic idle();
        op(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic count_busy(input string name);
        int cnt;
        cnt = 0;
        while (busy[0] && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        chk(name, cnt, RS);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_dout_a", dout_a[0], 32'h0);
        chk("rst_busy", {31'd0, busy[0]}, 32'd1);
        chk("rst_dval_a", {31'd0, dval_a[0]}, 32'd0);
        chk_en = 1'b1;
        #2 rst = 1'b0;
        count_busy("init_busy_cycles");

        // cleared memory reads zero
        op(1'b1, '0, 8'h55, '0, 1'b1, '0, 8'hAA, '0);
        repeat (LAT) idle();
        chk("clear_rd_a", dout_a[0], 32'h0);
        chk("clear_dval_a", {31'd0, dval_a[0]}, 32'd1);

        // byte-lane merge
        op(1'b1, 4'b1111, 8'h10, 32'hDEADBEEF, 1'b0, '0, '0, '0);
        op(1'b1, 4'b0001, 8'h10, 32'h000000AA, 1'b0, '0, '0, '0);
        op(1'b1, 4'b0000, 8'h10, '0, 1'b0, '0, '0, '0);
        repeat (LAT) idle();
        chk("lane_merge", dout_a[0], 32'hDEADBEAA);

        // both ports write same address
        op(1'b1, 4'b0011, 8'h20, 32'h11111111, 1'b1, 4'b0110, 8'h20, 32'h22222222);
        idle();
        chk("ww_coll_hi", {31'd0, coll[0]}, 32'd1);
        idle();
        chk("ww_coll_lo", {31'd0, coll[0]}, 32'd0);
        op(1'b1, 4'b0000, 8'h20, '0, 1'b0, '0, '0, '0);
        repeat (LAT) idle();
        chk("ww_merge", dout_a[0], 32'h00221111);

        // A reads while B writes same address
        op(1'b1, 4'b1111, 8'h30, 32'h5, 1'b0, '0, '0, '0);
        op(1'b1, 4'b0000, 8'h30, '0, 1'b1, 4'b1111, 8'h30, 32'h9);
        idle();
        chk("rw_coll", {31'd0, coll[0]}, 32'd1);
        repeat (LAT - 1) idle();
        chk("rw_old", dout_a[0], 32'h5);
        op(1'b1, 4'b0000, 8'h30, '0, 1'b0, '0, '0, '0);
        repeat (LAT) idle();
        chk("rw_after", dout_a[0], 32'h9);

        // read-during-write modes
        op(1'b1, 4'b1111, 8'h40, 32'h3, 1'b0, '0, '0, '0);
        op(1'b1, 4'b0000, 8'h40, '0, 1'b0, '0, '0, '0);
        op(1'b1, 4'b1111, 8'h40, 32'h7, 1'b0, '0, '0, '0);
        repeat (LAT) idle();
        chk("rdw0_dout", dout_a[0], 32'h3);
        chk("rdw1_dout", dout_a[1], 32'h7);
        chk("rdw2_dout", dout_a[2], 32'h3);
        chk("rdw1_dval", {31'd0, dval_a[1]}, 32'd1);
        chk("rdw2_dval", {31'd0, dval_a[2]}, 32'd0);

        // independent addresses, then shared read (no collision)
        op(1'b1, 4'b1111, 8'h50, 32'h12345678, 1'b1, 4'b1111, 8'h51, 32'hCAFEF00D);
        op(1'b1, 4'b0000, 8'h51, '0, 1'b1, 4'b0000, 8'h50, '0);
        repeat (LAT) idle();
        chk("indep_a", dout_a[0], 32'hCAFEF00D);
        chk("indep_b", dout_b[0], 32'h12345678);
        op(1'b1, 4'b0000, 8'h50, '0, 1'b1, 4'b0000, 8'h50, '0);
        idle();
        chk("rr_no_coll", {31'd0, coll[0]}, 32'd0);

        // mixed traffic on a small window to provoke collisions
        for (int i = 0; i < 60; i++) begin
            op(1'($urandom_range(0, 1)), 4'($urandom), 8'h60 + 8'($urandom_range(0, 3)), $urandom,
               1'($urandom_range(0, 1)), 4'($urandom), 8'h60 + 8'($urandom_range(0, 3)), $urandom);
        end
        idle();

        // measured read latency
        op(1'b1, 4'b0000, 8'h10, '0, 1'b0, '0, '0, '0);
        n = 0;
        while (n < 8) begin
            @(negedge clk);
            en_a = 1'b0;
            n++;
            if (dval_a[0]) break;
        end
        chk("latency", n, LAT);
        repeat (3) idle();

        // reset while operating, then again mid-sweep at counter 100
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst2_dout_a", dout_a[0], 32'h0);
        chk("rst2_busy", {31'd0, busy[0]}, 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (100) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        count_busy("reinit_busy_cycles");
        op(1'b1, 4'b0000, 8'h10, '0, 1'b0, '0, '0, '0);
        repeat (LAT) idle();
        chk("reinit_clear", dout_a[0], 32'h0);
        chk("reinit_dval", {31'd0, dval_a[0]}, 32'd1);

        repeat (3) idle();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tdpr_be_ram.md
TDPR_BE_RAM -- requirements
Module: tdpr_be_ram

Interface
REQ-001 Parameter ADDR_SIZE, default 8, address width; depth RAM_SIZE = 2**ADDR_SIZE words.
REQ-002 Parameter DATA_SIZE, default 32, word width; SHALL be a multiple of BYTE_SIZE.
REQ-003 Parameter BYTE_SIZE, default 8, lane width; NBYTES = DATA_SIZE/BYTE_SIZE.
REQ-004 Parameter RDW_MODE, default 0, same-port read-during-write: 0 read-first (old data), 1 write-first (new data), 2 no-change (dout holds).
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 init_busy  out  1  high while post-reset clear sweep runs; ports ignored.
REQ-008 en_a / en_b  in  1  port enable.
REQ-009 we_a / we_b  in  NBYTES  per-lane write enable; all-zero = read.
REQ-010 addr_a / addr_b  in  ADDR_SIZE  word address.
REQ-011 din_a / din_b  in  DATA_SIZE  write data.
REQ-012 dout_a / dout_b  out  DATA_SIZE  read data.
REQ-013 dval_a / dval_b  out  1  dout valid strobe, one cycle per accepted access that updates dout.
REQ-014 coll  out  1  one-cycle pulse on same-address conflict between ports.

Function
REQ-015 FSM states INIT and READY; reset enters INIT with clear counter 0.
REQ-016 INIT: one zero word written per cycle at counter address, counter increments; after RAM_SIZE-1 written, next state READY; init_busy = (state==INIT).
REQ-017 In INIT, en/we inputs ignored; no dval, no coll.
REQ-018 READY: port access accepted when en_x=1; read latency 1 cycle (dout_x, dval_x valid at next edge).
REQ-019 Write: only lanes with we_x[i]=1 updated; other lanes keep contents.
REQ-020 Write cycle dout per RDW_MODE: 0 old word, 1 merged new word, 2 dout unchanged and dval_x=0.
REQ-021 en_x=0: dout_x holds last value, dval_x=0 (no high-Z).
REQ-022 Both ports write same address same cycle: per lane, A wins where both we bits set; lanes written by one port take that port's data; coll=1 next cycle.
REQ-023 One port reads, other writes same address same cycle: reader gets old word; coll=1 next cycle.
REQ-024 Both read same address: no conflict, coll=0.
REQ-025 Different addresses: ports fully independent.

Reset
REQ-026 On rst assertion, immediately: dout_a/b=0, dval_a/b=0, coll=0, state INIT, counter 0, init_busy=1.
REQ-027 Reset mid-INIT or mid-operation restarts sweep at address 0; memory contents undefined until sweep completes.
REQ-028 Memory array itself not reset; cleared only by INIT sweep.

Configuration
REQ-029 Macro TDPR_OUT_REG_EN: when defined, one extra output register stage per port; read latency 2, dval delayed identically, coll unaffected (latency 1).
REQ-030 Without TDPR_OUT_REG_EN: read latency 1 as in REQ-018.

Structure
REQ-031 Package tdpr_pkg holds RDW_MODE encodings (RDW_READ_FIRST=0, RDW_WRITE_FIRST=1, RDW_NO_CHANGE=2) and FSM state typedef.
REQ-032 One sub-module tdpr_be_lane_mux: per-lane write-data/collision merge; instantiated once.

Verification
REQ-033 Reset release -> init_busy high exactly RAM_SIZE cycles (256 default); then read any addr -> 0x00000000.
REQ-034 A writes 0xDEADBEEF addr 0x10 we=4'b1111, then we=4'b0001 data 0x000000AA -> read returns 0xDEADBEAA.
REQ-035 Same cycle A we=4'b0011 0x11111111, B we=4'b0110 0x22222222 addr 0x20 -> memory 0x00221111, coll pulse 1 cycle.
REQ-036 A reads 0x30 (holding 0x5), B writes 0x9 to 0x30 same cycle -> dout_a=0x5, coll=1; subsequent read 0x9.
REQ-037 RDW_MODE 0/1/2: write 0x7 over 0x3 -> dout 0x3 / 0x7 / unchanged with dval=0.
REQ-038 rst pulse during INIT at counter 100 -> sweep restarts, init_busy high another 256 cycles; with TDPR_OUT_REG_EN read latency measured 2.
